// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the memory bus arbiter.
//   arb_state_e : FSM state encoding (IDLE / ACCESS / RESP)
//   REQ_F/REQ_D : requester IDs as driven on gnt_id
//   BUS_RD/BUS_WR : bus direction values as driven on WR_RD
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_e;

  localparam logic REQ_F  = 1'b0;
  localparam logic REQ_D  = 1'b1;

  localparam logic BUS_RD = 1'b0;
  localparam logic BUS_WR = 1'b1;

endpackage

// File: rtl/mem_bus_arbiter_grant_sel.sv
// arb_grant_sel: combinational winner pick between fetch (F) and data (D).
// Optional feature macro: MEM_ARB_ROUND_ROBIN_EN
//   undefined : fixed priority D > F; i_last_id is ignored
//   defined   : on a tie, grant the requester that did not win last time
// Ports:
//   i_f_req, i_d_req : request lines
//   i_last_id        : winner of the previous arbitration
//   o_gnt_valid      : at least one request present
//   o_gnt_id         : winning requester (REQ_F / REQ_D)
module arb_grant_sel
  import mem_arb_pkg::*;
(
  input  logic i_f_req,
  input  logic i_d_req,
  input  logic i_last_id,
  output logic o_gnt_valid,
  output logic o_gnt_id
);

  always_comb begin
    o_gnt_valid = i_f_req | i_d_req;
    o_gnt_id    = REQ_F;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    if (i_f_req && i_d_req) begin
      o_gnt_id = ~i_last_id;
    end else if (i_d_req) begin
      o_gnt_id = REQ_D;
    end
`else
    if (i_d_req) begin
      o_gnt_id = REQ_D;
    end
`endif
  end

`ifndef MEM_ARB_ROUND_ROBIN_EN
  // Fixed priority has no use for the last winner.
  logic w_unused_last;
  assign w_unused_last = i_last_id;
`endif

endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares the external memory bus between instruction fetch
// (F, read-only) and load/store data (D). Each access holds CS high for
// WAIT_CYCLES cycles, then pulses the winner's done for one cycle.
// Optional feature macro: MEM_ARB_ROUND_ROBIN_EN (round-robin tie break).
// Ports:
//   CLK, rst (async active-low)
//   f_req/f_addr/f_done                  : fetch requester
//   d_req/d_we/d_addr/d_wdata/d_done     : data requester
//   rdata                                : read data, held until next read
//   ADDR/Data_BUS_WRITE/Data_BUS_READ/CS/WR_RD : external bus
//   bus_busy, gnt_id                     : status
module mem_bus_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 2,
  parameter int unsigned CNT_W       = 4,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32
) (
  input  logic              CLK,
  input  logic              rst,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_done,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_done,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] ADDR,
  output logic [DATA_W-1:0] Data_BUS_WRITE,
  input  logic [DATA_W-1:0] Data_BUS_READ,
  output logic              CS,
  output logic              WR_RD,
  output logic              bus_busy,
  output logic              gnt_id
);

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WAIT_CYCLES - 1);

  arb_state_e        r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic              r_cs, w_cs_nxt;
  logic              r_wr, w_wr_nxt;
  logic              r_f_done, w_f_done_nxt;
  logic              r_d_done, w_d_done_nxt;
  logic              r_busy, w_busy_nxt;
  logic              r_gnt, w_gnt_nxt;
  logic [ADDR_W-1:0] r_addr, w_addr_nxt;
  logic [DATA_W-1:0] r_wdata, w_wdata_nxt;
  logic [DATA_W-1:0] r_rdata, w_rdata_nxt;
  logic              w_gnt_valid, w_gnt_id;
  logic              w_last_id;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic r_last_id, w_last_nxt;
  assign w_last_id = r_last_id;
`else
  assign w_last_id = REQ_D;
`endif

  arb_grant_sel u_grant_sel (
    .i_f_req     (f_req),
    .i_d_req     (d_req),
    .i_last_id   (w_last_id),
    .o_gnt_valid (w_gnt_valid),
    .o_gnt_id    (w_gnt_id)
  );

  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_cs     <= 1'b0;
      r_wr     <= BUS_RD;
      r_f_done <= 1'b0;
      r_d_done <= 1'b0;
      r_busy   <= 1'b0;
      r_gnt    <= REQ_F;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      r_last_id <= REQ_D;
`endif
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_cs     <= w_cs_nxt;
      r_wr     <= w_wr_nxt;
      r_f_done <= w_f_done_nxt;
      r_d_done <= w_d_done_nxt;
      r_busy   <= w_busy_nxt;
      r_gnt    <= w_gnt_nxt;
      r_addr   <= w_addr_nxt;
      r_wdata  <= w_wdata_nxt;
      r_rdata  <= w_rdata_nxt;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      r_last_id <= w_last_nxt;
`endif
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_cs_nxt     = r_cs;
    w_wr_nxt     = r_wr;
    w_f_done_nxt = 1'b0;
    w_d_done_nxt = 1'b0;
    w_gnt_nxt    = r_gnt;
    w_addr_nxt   = r_addr;
    w_wdata_nxt  = r_wdata;
    w_rdata_nxt  = r_rdata;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    w_last_nxt   = r_last_id;
`endif
    unique case (r_state)
      IDLE: begin
        if (w_gnt_valid) begin
          w_state_nxt = ACCESS;
          w_cs_nxt    = 1'b1;
          w_cnt_nxt   = CNT_INIT;
          w_gnt_nxt   = w_gnt_id;
`ifdef MEM_ARB_ROUND_ROBIN_EN
          w_last_nxt  = w_gnt_id;
`endif
          if (w_gnt_id == REQ_D) begin
            w_addr_nxt  = d_addr;
            w_wdata_nxt = d_wdata;
            w_wr_nxt    = d_we ? BUS_WR : BUS_RD;
          end else begin
            // Fetch has no write data; the bus keeps its last value.
            w_addr_nxt  = f_addr;
            w_wr_nxt    = BUS_RD;
          end
        end
      end
      ACCESS: begin
        if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end else begin
          if (r_wr == BUS_RD) begin
            w_rdata_nxt = Data_BUS_READ;
          end
          w_cs_nxt    = 1'b0;
          w_state_nxt = RESP;
          if (r_gnt == REQ_D) w_d_done_nxt = 1'b1;
          else                w_f_done_nxt = 1'b1;
        end
      end
      RESP: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
    // Registered so bus_busy tracks the state it will be in next cycle.
    w_busy_nxt = (w_state_nxt != IDLE);
  end

  assign CS             = r_cs;
  assign WR_RD          = r_wr;
  assign f_done         = r_f_done;
  assign d_done         = r_d_done;
  assign bus_busy       = r_busy;
  assign gnt_id         = r_gnt;
  assign ADDR           = r_addr;
  assign Data_BUS_WRITE = r_wdata;
  assign rdata          = r_rdata;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: scoreboard bench for mem_bus_arbiter (WAIT_CYCLES = 2).
// Expected accesses are queued when requests are driven and checked by a bus
// monitor as CS / done activity appears.
module tb_mem_bus_arbiter;

  localparam int WAIT = 2;
  localparam logic [31:0] BUS_K = 32'h5A5A_5A5A;

  logic        CLK = 1'b0;
  logic        rst;
  logic        f_req, f_done, d_req, d_we, d_done;
  logic [31:0] f_addr, d_addr, d_wdata, rdata;
  logic [31:0] ADDR, Data_BUS_WRITE, Data_BUS_READ;
  logic        CS, WR_RD, bus_busy, gnt_id;

  mem_bus_arbiter #(.WAIT_CYCLES(WAIT), .CNT_W(4), .ADDR_W(32), .DATA_W(32)) dut (
    .CLK(CLK), .rst(rst),
    .f_req(f_req), .f_addr(f_addr), .f_done(f_done),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_done(d_done),
    .rdata(rdata), .ADDR(ADDR), .Data_BUS_WRITE(Data_BUS_WRITE),
    .Data_BUS_READ(Data_BUS_READ), .CS(CS), .WR_RD(WR_RD),
    .bus_busy(bus_busy), .gnt_id(gnt_id)
  );

  always #5 CLK = ~CLK;

  // Bus memory model: fixed value when requested, else address-derived.
  logic        rd_fixed_en = 1'b0;
  logic [31:0] rd_fixed    = '0;
  always_comb Data_BUS_READ = rd_fixed_en ? rd_fixed : (ADDR ^ BUS_K);

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  typedef struct {
    logic        id;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] m_rdata = '0;
  logic        m_last  = 1'b1;

  task automatic push_exp(input logic id, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata);
    exp_t e;
    e.id = id; e.we = we; e.addr = addr; e.wdata = wdata;
    if (we) e.rdata = m_rdata;
    else begin
      e.rdata = rd_fixed_en ? rd_fixed : (addr ^ BUS_K);
      m_rdata = e.rdata;
    end
    sb.push_back(e);
  endtask

  task automatic predict(input logic f, input logic d, output logic w);
`ifdef MEM_ARB_ROUND_ROBIN_EN
    if (f && d) w = ~m_last;
    else        w = d;
`else
    w = d;
`endif
    m_last = w;
  endtask

  // Bus / completion monitor.
  int   cyc = 0;
  int   rise_cyc = 0;
  int   cs_len = 0;
  int   done_cnt = 0;
  logic prev_cs = 1'b0;
  logic mon_en = 1'b0;

  always @(posedge CLK) cyc++;

  always @(negedge CLK) begin
    if (!mon_en) begin
      prev_cs = 1'b0;
    end else begin
      if (CS) begin
        if (!prev_cs) begin
          rise_cyc = cyc;
          cs_len   = 0;
          chk_eq("cs_expected", (sb.size() != 0), 1'b1);
          if (sb.size() != 0) chk_eq("gnt_id", gnt_id, sb[0].id);
        end
        cs_len++;
        if (sb.size() != 0) begin
          chk_eq("bus_addr", ADDR, sb[0].addr);
          chk_eq("bus_wr_rd", WR_RD, sb[0].we);
          if (sb[0].we) chk_eq("bus_wdata", Data_BUS_WRITE, sb[0].wdata);
        end
      end else if (prev_cs) begin
        chk_eq("cs_len", cs_len, WAIT);
      end
      if (f_done || d_done) begin
        chk_eq("done_expected", (sb.size() != 0), 1'b1);
        chk_eq("done_single", (f_done & d_done), 1'b0);
        if (sb.size() != 0) begin
          exp_t e;
          e = sb.pop_front();
          chk_eq("done_id", d_done, e.id);
          chk_eq("rdata", rdata, e.rdata);
          chk_eq("done_latency", cyc - rise_cyc, WAIT);
          chk_eq("busy_resp", bus_busy, 1'b1);
        end
        done_cnt++;
      end
      prev_cs = CS;
    end
  end

  task automatic wait_dones(input int target);
    int n = 0;
    while (done_cnt < target && n < 40) begin
      @(negedge CLK); #1;
      n++;
    end
    chk_eq("done_count", done_cnt, target);
  endtask

  task automatic wait_cs();
    int n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (!CS && n < 20);
    chk_eq("cs_seen", CS, 1'b1);
  endtask

  task automatic contention(input logic [31:0] fa, input logic [31:0] da);
    logic w1, w2;
    int   base;
    base = done_cnt;
    predict(1'b1, 1'b1, w1);
    predict(w1 == 1'b0, w1 == 1'b1 ? 1'b0 : 1'b1, w2);
    push_exp(w1, 1'b0, w1 ? da : fa, 32'h0);
    push_exp(w2, 1'b0, w2 ? da : fa, 32'h0);
    @(negedge CLK);
    f_addr = fa; d_addr = da; d_we = 1'b0;
    f_req = 1'b1; d_req = 1'b1;
    wait_dones(base + 1);
    if (w1) d_req = 1'b0; else f_req = 1'b0;
    wait_dones(base + 2);
    f_req = 1'b0; d_req = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    f_req = 0; d_req = 0; d_we = 0;
    f_addr = '0; d_addr = '0; d_wdata = '0;

    // Reset state
    repeat (2) @(negedge CLK);
    chk_eq("rst_cs", CS, 1'b0);
    chk_eq("rst_busy", bus_busy, 1'b0);
    chk_eq("rst_done", {f_done, d_done}, 2'b00);
    chk_eq("rst_gnt", gnt_id, 1'b0);
    chk_eq("rst_addr", ADDR, 32'h0);
    chk_eq("rst_wdata", Data_BUS_WRITE, 32'h0);
    chk_eq("rst_rdata", rdata, 32'h0);
    rst = 1'b1;
    mon_en = 1'b1;
    @(negedge CLK);

    // Single fetch; address changes after grant must not reach the bus
    rd_fixed_en = 1'b1; rd_fixed = 32'hAAAA_AAAA;
    begin
      logic w;
      predict(1'b1, 1'b0, w);
      push_exp(w, 1'b0, 32'h0040_0000, 32'h0);
    end
    f_addr = 32'h0040_0000; f_req = 1'b1;
    @(negedge CLK); f_addr = 32'hDEAD_BEEF;
    wait_dones(1);
    f_req = 1'b0;

    // Store: rdata unchanged even though the bus shows other data
    @(negedge CLK);
    rd_fixed = 32'h5555_5555;
    begin
      logic w;
      predict(1'b0, 1'b1, w);
      push_exp(w, 1'b1, 32'h1001_0004, 32'h1234_5678);
    end
    d_addr = 32'h1001_0004; d_wdata = 32'h1234_5678; d_we = 1'b1; d_req = 1'b1;
    @(negedge CLK); d_wdata = 32'hFFFF_0000; d_addr = 32'h0;
    wait_dones(2);
    d_req = 1'b0; d_we = 1'b0;
    rd_fixed_en = 1'b0;

    // Simultaneous requests
    @(negedge CLK);
    contention(32'h0040_0004, 32'h1001_0008);

    // Both held continuously for four accesses
    @(negedge CLK);
    begin
      logic w;
      int   base;
      base = done_cnt;
      for (int unsigned i = 0; i < 4; i++) begin
        predict(1'b1, 1'b1, w);
        push_exp(w, 1'b0, w ? 32'h1001_0100 : 32'h0040_0100, 32'h0);
      end
      f_addr = 32'h0040_0100; d_addr = 32'h1001_0100; d_we = 1'b0;
      f_req = 1'b1; d_req = 1'b1;
      wait_dones(base + 4);
      f_req = 1'b0; d_req = 1'b0;
    end

    // Early drop: request released mid-access still completes once
    @(negedge CLK);
    begin
      logic w;
      int   base;
      base = done_cnt;
      predict(1'b0, 1'b1, w);
      push_exp(w, 1'b1, 32'h1001_0200, 32'hCAFE_F00D);
      d_addr = 32'h1001_0200; d_wdata = 32'hCAFE_F00D; d_we = 1'b1; d_req = 1'b1;
      wait_cs();
      d_req = 1'b0;
      wait_dones(base + 1);
      repeat (6) @(negedge CLK);
      chk_eq("early_drop_once", done_cnt, base + 1);
      d_we = 1'b0;
    end

    // Asynchronous reset in the middle of an access
    mon_en = 1'b0;
    f_addr = 32'h0040_0300; f_req = 1'b1;
    wait_cs();
    #1 rst = 1'b0;
    #1;
    chk_eq("rst_mid_cs", CS, 1'b0);
    chk_eq("rst_mid_busy", bus_busy, 1'b0);
    chk_eq("rst_mid_rdata", rdata, 32'h0);
    chk_eq("rst_mid_done", {f_done, d_done}, 2'b00);
    chk_eq("rst_mid_addr", ADDR, 32'h0);
    f_req = 1'b0;
    repeat (2) @(negedge CLK);
    chk_eq("rst_hold_done", {f_done, d_done}, 2'b00);
    rst = 1'b1;
    m_rdata = '0; m_last = 1'b1;
    mon_en = 1'b1;
    repeat (4) @(negedge CLK);

    // Recovery fetch after reset
    begin
      logic w;
      int   base;
      base = done_cnt;
      predict(1'b1, 1'b0, w);
      push_exp(w, 1'b0, 32'h0040_0400, 32'h0);
      f_addr = 32'h0040_0400; f_req = 1'b1;
      wait_dones(base + 1);
      f_req = 1'b0;
    end
    repeat (4) @(negedge CLK);
    chk_eq("sb_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
